// File: rtl/pc_gen.sv
// Program-counter generator: PC register, next-fetch-address selection and an optional
// return-address stack, built only when the PC_GEN_RAS_EN macro is defined.
module pc_gen #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             exc_req,
    input  logic [2:0]       npcop,
    input  logic             br_taken,
    input  logic [15:0]      imm16,
    input  logic [25:0]      imm26,
    input  logic [WIDTH-1:0] rs_data,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] npc,
    output logic             addr_err,
    output logic             ras_hit
);

    localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] EXC_VEC_W  = WIDTH'(EXC_VEC);

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

    logic [WIDTH-1:0] pc_r;
    logic             addr_err_r;
    logic [WIDTH-1:0] pc_plus4_s;
    logic [WIDTH-1:0] br_tgt_s;
    logic [WIDTH-1:0] jmp_tgt_s;
    logic [WIDTH-1:0] jr_tgt_s;
    logic             jr_err_s;
    logic [WIDTH-1:0] npc_s;
    logic             err_next_s;
    logic             ras_hit_s;

`ifdef PC_GEN_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0] top_r;
    logic [PTR_W-1:0] top_inc_s;
    logic [CNT_W-1:0] cnt_r;
    logic             ras_avail_s;
    logic [WIDTH-1:0] ras_top_s;
    logic             push_s;
    logic             pop_s;
`endif

    // Candidate targets; a misaligned register target is redirected to the vector
    always_comb begin
        pc_plus4_s = pc_r + WIDTH'(32'd4);
        br_tgt_s   = pc_plus4_s + {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
        jmp_tgt_s  = {pc_r[WIDTH-1:28], imm26, 2'b00};
        jr_err_s   = misaligned(rs_data[1:0]);
        if (jr_err_s) begin
            jr_tgt_s = EXC_VEC_W;
        end else begin
            jr_tgt_s = rs_data;
        end
    end

`ifdef PC_GEN_RAS_EN
    // Stack pointers: the pointer wraps naturally because the depth is a power of two
    always_comb begin
        top_inc_s   = top_r + PTR_W'(1);
        ras_avail_s = cnt_r != {CNT_W{1'b0}};
        ras_top_s   = ras_mem_r[top_r];
    end
`endif

    // Next-PC selection with rst > exc_req > stall > npcop priority
    always_comb begin
        npc_s      = pc_plus4_s;
        err_next_s = 1'b0;
        ras_hit_s  = 1'b0;
`ifdef PC_GEN_RAS_EN
        push_s     = 1'b0;
        pop_s      = 1'b0;
`endif
        if (rst) begin
            npc_s = RESET_PC_W;
        end else if (exc_req) begin
            npc_s = EXC_VEC_W;
        end else if (stall) begin
            npc_s = pc_r;
        end else begin
            case (npcop)
                3'b000: npc_s = pc_plus4_s;
                3'b001: npc_s = br_taken ? br_tgt_s : pc_plus4_s;
                3'b010: npc_s = jmp_tgt_s;
                3'b011: begin
                    npc_s      = jr_tgt_s;
                    err_next_s = jr_err_s;
                end
                3'b100: begin
                    npc_s = jmp_tgt_s;
`ifdef PC_GEN_RAS_EN
                    push_s = 1'b1;
`endif
                end
                3'b101: begin
`ifdef PC_GEN_RAS_EN
                    if (ras_avail_s) begin
                        npc_s     = ras_top_s;
                        ras_hit_s = 1'b1;
                        pop_s     = 1'b1;
                    end else begin
                        npc_s      = jr_tgt_s;
                        err_next_s = jr_err_s;
                    end
`else
                    npc_s      = jr_tgt_s;
                    err_next_s = jr_err_s;
`endif
                end
                default: npc_s = pc_plus4_s;
            endcase
        end
    end

    // Architectural PC and the one-cycle misaligned-target flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC_W;
            addr_err_r <= 1'b0;
        end else begin
            pc_r       <= npc_s;
            addr_err_r <= err_next_s;
        end
    end

`ifdef PC_GEN_RAS_EN
    // Stack bookkeeping; a push when full keeps the count saturated and overwrites the oldest
    always_ff @(posedge clk) begin
        if (rst) begin
            top_r <= {PTR_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (push_s) begin
            top_r <= top_inc_s;
            if (cnt_r != DEPTH_C) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else if (pop_s) begin
            top_r <= top_r - PTR_W'(1);
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

    // Stack storage carries no reset; entries are only read when counted valid
    always_ff @(posedge clk) begin
        if (push_s) begin
            ras_mem_r[top_inc_s] <= pc_plus4_s;
        end
    end
`endif

    assign pc       = pc_r;
    assign pc_plus4 = pc_plus4_s;
    assign npc      = npc_s;
    assign addr_err = addr_err_r;
    assign ras_hit  = ras_hit_s;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen; expected values follow PC_GEN_RAS_EN when it is defined.
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall;
    logic        exc_req;
    logic [2:0]  npcop;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] npc;
    logic        addr_err;
    logic        ras_hit;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        exc;
        logic [2:0]  op;
        logic        bt;
        logic [15:0] i16;
        logic [25:0] i26;
        logic [31:0] rs;
        logic [31:0] epc;
        logic        eerr;
        logic        ehit;
    } row_t;

    row_t stim_q[$];
    row_t exp_q[$];
    int   vectors;
    int   miscompares;

    pc_gen dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .exc_req  (exc_req),
        .npcop    (npcop),
        .br_taken (br_taken),
        .imm16    (imm16),
        .imm26    (imm26),
        .rs_data  (rs_data),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .npc      (npc),
        .addr_err (addr_err),
        .ras_hit  (ras_hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input logic r, input logic st, input logic ex, input logic [2:0] op,
                       input logic bt, input logic [15:0] i16, input logic [25:0] i26,
                       input logic [31:0] rs, input logic [31:0] epc, input logic eerr,
                       input logic ehit);
        row_t t;
        t.rst = r; t.stall = st; t.exc = ex; t.op = op; t.bt = bt;
        t.i16 = i16; t.i26 = i26; t.rs = rs; t.epc = epc; t.eerr = eerr; t.ehit = ehit;
        stim_q.push_back(t);
    endtask

    task automatic drive(input row_t s);
        rst = s.rst; stall = s.stall; exc_req = s.exc; npcop = s.op;
        br_taken = s.bt; imm16 = s.i16; imm26 = s.i26; rs_data = s.rs;
    endtask

    task automatic test_reset();
        row_t s;
        row_t e;
        int   n = 0;
        add(1, 0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 0, 0);
        add(0, 0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 0, 0);
        add(0, 0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 0, 0);
        add(0, 0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 32'h300C, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            exp_q.push_back(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (pc !== e.epc || addr_err !== e.eerr || pc_plus4 !== e.epc + 32'd4) begin
                miscompares++;
                $display("FAIL reset[%0d] pc=%h pc_plus4=%h addr_err=%b expected pc=%h pc_plus4=%h addr_err=%b",
                         n, pc, pc_plus4, addr_err, e.epc, e.epc + 32'd4, e.eerr);
            end
            n++;
        end
    endtask

    task automatic test_branch();
        row_t s;
        row_t e;
        int   n = 0;
        for (int k = 0; k < 2; k++) begin
            add(1, 0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 0, 0);
            for (int j = 1; j <= 4; j++) begin
                add(0, 0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 32'h3000 + 32'(4 * j), 0, 0);
            end
            if (k == 0) begin
                add(0, 0, 0, 3'd1, 1, 16'hFFFC, 26'h0, 32'h0, 32'h3004, 0, 0);
            end else begin
                add(0, 0, 0, 3'd1, 0, 16'h0003, 26'h0, 32'h0, 32'h3014, 0, 0);
                add(0, 0, 0, 3'd1, 1, 16'h0003, 26'h0, 32'h0, 32'h3024, 0, 0);
            end
        end
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            exp_q.push_back(s);
            #1;
            vectors++;
            if (npc !== exp_q[0].epc) begin
                miscompares++;
                $display("FAIL branch_npc[%0d] npc=%h expected %h", n, npc, exp_q[0].epc);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (pc !== e.epc || addr_err !== e.eerr) begin
                miscompares++;
                $display("FAIL branch_pc[%0d] pc=%h addr_err=%b expected pc=%h addr_err=%b",
                         n, pc, addr_err, e.epc, e.eerr);
            end
            n++;
        end
    endtask

    task automatic test_jump();
        row_t s;
        row_t e;
        int   n = 0;
        add(1, 0, 0, 3'd0, 0, 16'h0, 26'h0,     32'h0,    32'h3000, 0, 0);
        add(0, 0, 0, 3'd2, 0, 16'h0, 26'h0C40,  32'h0,    32'h3100, 0, 0);
        add(0, 0, 0, 3'd3, 0, 16'h0, 26'h0,     32'h3202, 32'h4180, 1, 0);
        add(0, 0, 0, 3'd0, 0, 16'h0, 26'h0,     32'h0,    32'h4184, 0, 0);
        add(0, 0, 0, 3'd3, 0, 16'h0, 26'h0,     32'h5000, 32'h5000, 0, 0);
        add(0, 1, 0, 3'd3, 0, 16'h0, 26'h0,     32'h3202, 32'h5000, 0, 0);
        add(0, 0, 1, 3'd3, 0, 16'h0, 26'h0,     32'h3202, 32'h4180, 0, 0);
        add(0, 0, 0, 3'd5, 0, 16'h0, 26'h0,     32'h6001, 32'h4180, 1, 0);
        add(0, 0, 0, 3'd6, 0, 16'h0, 26'h0,     32'h0,    32'h4184, 0, 0);
        add(0, 0, 0, 3'd7, 0, 16'h0, 26'h0,     32'h0,    32'h4188, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            exp_q.push_back(s);
            #1;
            vectors++;
            if (npc !== exp_q[0].epc) begin
                miscompares++;
                $display("FAIL jump_npc[%0d] npc=%h expected %h", n, npc, exp_q[0].epc);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (pc !== e.epc || addr_err !== e.eerr) begin
                miscompares++;
                $display("FAIL jump_pc[%0d] pc=%h addr_err=%b expected pc=%h addr_err=%b",
                         n, pc, addr_err, e.epc, e.eerr);
            end
            n++;
        end
    endtask

    task automatic test_priority();
        row_t s;
        row_t e;
        int   n = 0;
        add(1, 0, 0, 3'd0, 0, 16'h0, 26'h0,    32'h0, 32'h3000, 0, 0);
        add(0, 0, 0, 3'd0, 0, 16'h0, 26'h0,    32'h0, 32'h3004, 0, 0);
        add(0, 0, 0, 3'd0, 0, 16'h0, 26'h0,    32'h0, 32'h3008, 0, 0);
        add(0, 1, 1, 3'd0, 0, 16'h0, 26'h0,    32'h0, 32'h4180, 0, 0);
        for (int j = 0; j < 3; j++) begin
            add(0, 1, 0, 3'd2, 0, 16'h0, 26'h0C40, 32'h0, 32'h4180, 0, 0);
        end
        add(0, 0, 0, 3'd2, 0, 16'h0, 26'h0C40, 32'h0, 32'h3100, 0, 0);
        add(1, 0, 1, 3'd2, 0, 16'h0, 26'h0C40, 32'h0, 32'h3000, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            exp_q.push_back(s);
            #1;
            vectors++;
            if (npc !== exp_q[0].epc) begin
                miscompares++;
                $display("FAIL priority_npc[%0d] npc=%h expected %h", n, npc, exp_q[0].epc);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (pc !== e.epc || addr_err !== e.eerr) begin
                miscompares++;
                $display("FAIL priority_pc[%0d] pc=%h addr_err=%b expected pc=%h addr_err=%b",
                         n, pc, addr_err, e.epc, e.eerr);
            end
            n++;
        end
    endtask

    task automatic test_ras();
        row_t        s;
        row_t        e;
        int          n = 0;
        logic [31:0] ret_tgt [4];
        ret_tgt[0] = 32'h3404; ret_tgt[1] = 32'h3304; ret_tgt[2] = 32'h3204; ret_tgt[3] = 32'h3104;
        add(1, 0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 0, 0);
        for (int j = 1; j <= 5; j++) begin
            add(0, 0, 0, 3'd4, 0, 16'h0, 26'h0C00 + 26'(64 * j), 32'h0, 32'h3000 + 32'(256 * j), 0, 0);
        end
        add(0, 1, 0, 3'd5, 0, 16'h0, 26'h0, 32'h5000, 32'h3500, 0, 0);
        for (int j = 0; j < 4; j++) begin
            add(0, 0, 0, 3'd5, 0, 16'h0, 26'h0, 32'h5000, RAS_ON ? ret_tgt[j] : 32'h5000, 0, RAS_ON);
        end
        add(0, 0, 0, 3'd5, 0, 16'h0, 26'h0, 32'h5000, 32'h5000, 0, 0);
        add(1, 0, 0, 3'd4, 0, 16'h0, 26'h0C40, 32'h0, 32'h3000, 0, 0);
        add(0, 0, 0, 3'd5, 0, 16'h0, 26'h0, 32'h5000, 32'h5000, 0, 0);
        add(0, 0, 1, 3'd4, 0, 16'h0, 26'h0C40, 32'h0, 32'h4180, 0, 0);
        add(0, 0, 0, 3'd5, 0, 16'h0, 26'h0, 32'h5000, 32'h5000, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            exp_q.push_back(s);
            #1;
            vectors++;
            if (npc !== exp_q[0].epc || ras_hit !== exp_q[0].ehit) begin
                miscompares++;
                $display("FAIL ras_npc[%0d] npc=%h ras_hit=%b expected npc=%h ras_hit=%b",
                         n, npc, ras_hit, exp_q[0].epc, exp_q[0].ehit);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (pc !== e.epc || addr_err !== e.eerr) begin
                miscompares++;
                $display("FAIL ras_pc[%0d] pc=%h addr_err=%b expected pc=%h addr_err=%b",
                         n, pc, addr_err, e.epc, e.eerr);
            end
            n++;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; stall = 1'b0; exc_req = 1'b0; npcop = 3'd0;
        br_taken = 1'b0; imm16 = 16'h0; imm26 = 26'h0; rs_data = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_branch();
        test_jump();
        test_priority();
        test_ras();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the MIPS core. Holds the architectural PC register and selects the next fetch address: sequential, conditional branch, 26-bit jump, register jump, exception vector, and (optionally) return prediction from a small return-address stack. Sits at the head of the fetch stage, driven by the decoder's next-PC opcode, the branch comparator, and the hazard/exception logic.

## Interface
- WIDTH, 32, address width in bits; legal range 32..64.
- RESET_PC, 32'h0000_3000, PC value loaded on reset, zero-extended to WIDTH.
- EXC_VEC, 32'h0000_4180, exception handler address, zero-extended to WIDTH.
- RAS_DEPTH, 4, return-address stack entries, power of two ≥ 2. Used only with PC_GEN_RAS_EN.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC and RAS this cycle.
- exc_req  in  1  redirect to EXC_VEC; overrides stall.
- npcop  in  3  next-PC mode: 000 seq, 001 branch, 010 jump, 011 jump-register, 100 jal, 101 return; 110/111 treated as 000.
- br_taken  in  1  branch condition, sampled only for npcop=001.
- imm16  in  16  branch offset, in words.
- imm26  in  26  jump target index.
- rs_data  in  WIDTH  register operand for 011/101.
- pc  out  WIDTH  current PC, registered.
- pc_plus4  out  WIDTH  pc+4, combinational; link value for the register file.
- npc  out  WIDTH  address PC will load on the next edge when not stalled, combinational.
- addr_err  out  1  registered one-cycle pulse: a register-jump target was misaligned.
- ras_hit  out  1  combinational: current 101 target comes from the RAS. Tied 0 without PC_GEN_RAS_EN.

## Operation
- Arithmetic is modulo 2^WIDTH; no overflow detection.
- seq: npc = pc+4.
- branch: taken → pc+4 + (sign_ext(imm16) << 2); not taken → pc+4.
- jump / jal: npc = {pc[WIDTH-1:28], imm26, 2'b00}.
- jump-register / return: npc = rs_data. If rs_data[1:0] ≠ 0, npc = EXC_VEC and addr_err is set on the next edge.
- Next-PC priority: rst > exc_req (npc = EXC_VEC) > stall (npc = pc) > npcop.
- No delay slot. The link value for jal is pc+4.
- Return-address stack (PC_GEN_RAS_EN only):
  - Circular buffer with top pointer and occupancy count 0..RAS_DEPTH.
  - jal pushes pc+4. Push when full overwrites the oldest entry; count stays RAS_DEPTH.
  - return with count > 0: npc = top entry, ras_hit = 1, pop (count−1). rs_data and its alignment check are ignored.
  - return with count = 0: behaves as jump-register, ras_hit = 0, no state change.
  - No push or pop when rst, exc_req or stall is asserted.

## Timing
- Reset (rst high at an edge): pc = RESET_PC, addr_err = 0, RAS count = 0, top pointer = 0. RAS entry contents are don't-care.
- pc updates exactly one edge after npcop and its operands are presented.
- npc, pc_plus4 and ras_hit are purely combinational from pc, the inputs and RAS state, with zero latency.
- addr_err is high for exactly the one cycle after the misaligned register jump is accepted. It is not raised when that jump is stalled or pre-empted by exc_req.
- stall held for N cycles leaves pc and the RAS unchanged for N cycles. The held instruction's effect applies on the first unstalled edge.
- rst asserted mid-sequence discards any pending push or pop that cycle.

## Configuration
- PC_GEN_RAS_EN defined: the RAS is built. npcop 100 pushes and 101 predicts and pops as described above.
- PC_GEN_RAS_EN undefined:
  - No RAS storage is built.
  - npcop 100 behaves exactly as 010.
  - npcop 101 behaves exactly as 011, including the alignment check.
  - ras_hit is constant 0.
  - RAS_DEPTH is ignored.

## Test plan
- Reset and sequential: assert rst, then 3 cycles of npcop=000 → pc = 0x3000, 0x3004, 0x3008, 0x300C; addr_err = 0.
- Branches: at pc=0x3010, npcop=001, imm16=0xFFFC, br_taken=1 → next pc = 0x3004. With imm16=0x0003, br_taken=0 → 0x3014.
- Jump and misaligned register jump: at pc=0x3000, npcop=010, imm26=0x0000C40 → 0x3100. Then npcop=011, rs_data=0x3202 → pc = 0x4180 and addr_err pulses one cycle.
- Priority: stall=1 with exc_req=1 at pc=0x3008 → pc = 0x4180. stall=1 alone for 3 cycles with npcop=010 → pc holds, then jumps on the first unstalled edge.
- RAS (macro on, RAS_DEPTH=4):
  - jal at 0x3000, 0x3100, 0x3200, 0x3300, 0x3400 (5 pushes, oldest 0x3004 dropped).
  - Five returns with rs_data=0x5000 → targets 0x3404, 0x3304, 0x3204, 0x3104 with ras_hit=1, then 0x5000 with ras_hit=0.
- RAS compiled out: same stimulus → every return goes to 0x5000; ras_hit is always 0.
